// File: rtl/cache_arbiter.sv
// Shares one memory port between I-cache and D-cache line traffic, one transaction at a time.
// Tie-break is fixed D-priority by default; defining CACHE_ARB_RR_EN selects round-robin.
module cache_arbiter #(
   parameter int s_line = 256,
   parameter int s_addr = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [s_addr-1:0] i_address,
   input  logic [s_line-1:0] i_wdata,
   output logic [s_line-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [s_addr-1:0] d_address,
   input  logic [s_line-1:0] d_wdata,
   output logic [s_line-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [s_addr-1:0] mem_address,
   output logic [s_line-1:0] mem_wdata,
   input  logic [s_line-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

   state_t            state_q, state_d;
   logic              gnt_d_q, gnt_d_d;
   logic              op_wr_q, op_wr_d;
   logic [s_addr-1:0] addr_q, addr_d;
   logic [s_line-1:0] wdata_q, wdata_d;
   logic [s_line-1:0] i_rdata_q, i_rdata_d;
   logic [s_line-1:0] d_rdata_q, d_rdata_d;
   logic              err_q, err_d;
`ifdef CACHE_ARB_RR_EN
   logic              last_d_q, last_d_d;
`endif

   logic i_req, d_req, pick_d, serving, op_held;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_d_q   <= 1'b0;
         op_wr_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         err_q     <= 1'b0;
`ifdef CACHE_ARB_RR_EN
         last_d_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_d_q   <= gnt_d_d;
         op_wr_q   <= op_wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         err_q     <= err_d;
`ifdef CACHE_ARB_RR_EN
         last_d_q  <= last_d_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d_d   = gnt_d_q;
      op_wr_d   = op_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      err_d     = err_q;
`ifdef CACHE_ARB_RR_EN
      last_d_d  = last_d_q;
`endif

      i_req = i_read | i_write;
      d_req = d_read | d_write;
`ifdef CACHE_ARB_RR_EN
      // On a tie the side that did not win last time takes the grant.
      pick_d = d_req & (~i_req | ~last_d_q);
`else
      pick_d = d_req;
`endif
      // The strobe matching the captured op must stay up for the whole service.
      op_held = (state_q == SERVE_D) ? (op_wr_q ? d_write : d_read)
                                     : (op_wr_q ? i_write : i_read);

      case (state_q)
         IDLE: begin
            if (mem_resp) err_d = 1'b1;
            if (i_req | d_req) begin
               gnt_d_d = pick_d;
`ifdef CACHE_ARB_RR_EN
               last_d_d = pick_d;
`endif
               if (pick_d) begin
                  state_d = SERVE_D;
                  addr_d  = d_address;
                  wdata_d = d_wdata;
                  op_wr_d = d_write;
                  if (d_read & d_write) err_d = 1'b1;
               end else begin
                  state_d = SERVE_I;
                  addr_d  = i_address;
                  wdata_d = i_wdata;
                  op_wr_d = i_write;
                  if (i_read & i_write) err_d = 1'b1;
               end
            end
         end
         SERVE_I, SERVE_D: begin
            if (!op_held) err_d = 1'b1;
            if (mem_resp) begin
               state_d = DONE;
               if (state_q == SERVE_D) d_rdata_d = mem_rdata;
               else                    i_rdata_d = mem_rdata;
            end
         end
         DONE: begin
            if (mem_resp) err_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign serving     = (state_q == SERVE_I) || (state_q == SERVE_D);
   assign mem_read    = serving & ~op_wr_q;
   assign mem_write   = serving & op_wr_q;
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;
   assign i_resp      = (state_q == DONE) & ~gnt_d_q;
   assign d_resp      = (state_q == DONE) & gnt_d_q;
   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign err         = err_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter against a transaction-level reference model.
module tb_cache_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_read, i_write, d_read, d_write;
   logic [31:0]  i_address, d_address;
   logic [255:0] i_wdata, d_wdata, i_rdata, d_rdata;
   logic         i_resp, d_resp;
   logic         mem_read, mem_write, mem_resp;
   logic [31:0]  mem_address;
   logic [255:0] mem_wdata, mem_rdata;
   logic         err;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: pending requests, last winner, sticky error, returned lines.
   bit           pi_rd, pi_wr, pd_rd, pd_wr;
   logic [31:0]  ai, ad;
   logic [255:0] wi, wd;
   bit           last_d;
   bit           err_exp;
   logic [255:0] ri_exp, rd_exp;

   cache_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic drive();
      i_read = pi_rd; i_write = pi_wr; i_address = ai; i_wdata = wi;
      d_read = pd_rd; d_write = pd_wr; d_address = ad; d_wdata = wd;
   endtask

   task automatic model_reset();
      pi_rd = 0; pi_wr = 0; pd_rd = 0; pd_wr = 0;
      ai = '0; ad = '0; wi = '0; wd = '0;
      last_d = 0; err_exp = 0; ri_exp = '0; rd_exp = '0;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_mrd"}, 256'(mem_read), 256'(0));
      chk({tag, "_mwr"}, 256'(mem_write), 256'(0));
      chk({tag, "_iresp"}, 256'(i_resp), 256'(0));
      chk({tag, "_dresp"}, 256'(d_resp), 256'(0));
      chk({tag, "_err"}, 256'(err), 256'(err_exp));
   endtask

   task automatic rand_op(output bit rd, output bit wr);
      int r;
      r = $urandom_range(0, 9);
      rd = (r == 0) || (r >= 5);
      wr = (r <= 4);
   endtask

   // One full grant/serve/respond cycle, starting with the DUT idle and inputs driven.
   task automatic run_txn(input bit drop, input int lat, input logic [255:0] line);
      bit ireq, dreq, win_d, is_wr;
      logic [31:0]  a;
      logic [255:0] w;
      ireq = pi_rd | pi_wr;
      dreq = pd_rd | pd_wr;
      if (ireq && dreq) begin
`ifdef CACHE_ARB_RR_EN
         win_d = !last_d;
`else
         win_d = 1;
`endif
      end else begin
         win_d = dreq;
      end
      last_d = win_d;
      is_wr = win_d ? pd_wr : pi_wr;
      if (win_d ? (pd_rd && pd_wr) : (pi_rd && pi_wr)) err_exp = 1;
      a = win_d ? ad : ai;
      w = win_d ? wd : wi;

      @(posedge clk); #1;
      chk("grant_mrd", 256'(mem_read), 256'(!is_wr));
      chk("grant_mwr", 256'(mem_write), 256'(is_wr));
      chk("grant_addr", 256'(mem_address), 256'(a));
      chk("grant_wdata", mem_wdata, w);
      chk("grant_err", 256'(err), 256'(err_exp));
      if (drop) begin
         if (win_d) begin pd_rd = 0; pd_wr = 0; end
         else       begin pi_rd = 0; pi_wr = 0; end
         drive();
         err_exp = 1;
      end
      for (int k = 0; k < lat; k++) begin
         @(posedge clk); #1;
         chk("hold_addr", 256'(mem_address), 256'(a));
         chk("hold_wdata", mem_wdata, w);
         chk("hold_mwr", 256'(mem_write), 256'(is_wr));
         chk("hold_noresp", 256'(i_resp | d_resp), 256'(0));
      end
      mem_rdata = line;
      mem_resp  = 1;
      @(posedge clk); #1;
      mem_resp = 0;
      if (win_d) rd_exp = line; else ri_exp = line;
      chk("done_iresp", 256'(i_resp), 256'(!win_d));
      chk("done_dresp", 256'(d_resp), 256'(win_d));
      chk("done_irdata", i_rdata, ri_exp);
      chk("done_drdata", d_rdata, rd_exp);
      chk("done_mstrobe", 256'(mem_read | mem_write), 256'(0));
      chk("done_err", 256'(err), 256'(err_exp));
      @(posedge clk); #1;
      check_quiet("idle");
      if (win_d) begin pd_rd = 0; pd_wr = 0; end
      else       begin pi_rd = 0; pi_wr = 0; end
      drive();
   endtask

   task automatic drain();
      while (pi_rd | pi_wr | pd_rd | pd_wr)
         run_txn(0, $urandom_range(0, 3), rand_line());
   endtask

   task automatic hard_reset();
      rst = 1;
      model_reset();
      drive();
      #1;
      chk("rst_mrd", 256'(mem_read), 256'(0));
      chk("rst_mwr", 256'(mem_write), 256'(0));
      chk("rst_addr", 256'(mem_address), 256'(0));
      chk("rst_wdata", mem_wdata, '0);
      chk("rst_irdata", i_rdata, '0);
      chk("rst_drdata", d_rdata, '0);
      chk("rst_resp", 256'(i_resp | d_resp), 256'(0));
      chk("rst_err", 256'(err), 256'(0));
      @(negedge clk);
      rst = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      mem_resp = 0;
      mem_rdata = '0;
      hard_reset();

      // Lone I-cache read, memory answers after 3 cycles.
      pi_rd = 1; ai = 32'h0000_1000; drive();
      run_txn(0, 3, {8{32'hA5A5_A5A5}});

      // Lone D-cache writeback.
      pd_wr = 1; ad = 32'h0000_2040; wd = {8{32'h1234_5678}}; drive();
      run_txn(0, 2, rand_line());

      // Tie held over four transactions from a fresh reset.
      hard_reset();
      pi_rd = 1; pd_rd = 1; ai = 32'h100; ad = 32'h200; drive();
      for (int t = 0; t < 4; t++) begin
         run_txn(0, $urandom_range(0, 3), rand_line());
         if (!pi_rd) begin pi_rd = 1; ai = $urandom; end
         if (!pd_rd) begin pd_rd = 1; ad = $urandom; end
         drive();
      end
      drain();

      // Stray memory response while idle.
      mem_resp = 1;
      @(posedge clk); #1;
      mem_resp = 0;
      err_exp = 1;
      check_quiet("stray");
      @(posedge clk); #1;
      check_quiet("stray_sticky");

      // Reset while SERVE_D is waiting on memory.
      pd_wr = 1; ad = 32'h3000; wd = rand_line(); drive();
      @(posedge clk); #1;
      chk("pre_rst_mwr", 256'(mem_write), 256'(1));
      hard_reset();
      pi_rd = 1; ai = 32'h4000; drive();
      run_txn(0, 0, rand_line());

      // D-cache raises read and write together.
      pd_rd = 1; pd_wr = 1; ad = 32'h5000; wd = rand_line(); drive();
      run_txn(0, 1, rand_line());

      // Requester abandons its strobe mid-service.
      hard_reset();
      pi_wr = 1; ai = 32'h6000; wi = rand_line(); drive();
      run_txn(1, 2, rand_line());

      // Randomized traffic.
      hard_reset();
      for (int n = 0; n < 80; n++) begin
         if (!(pi_rd | pi_wr) && ($urandom_range(0, 1) == 1)) begin
            rand_op(pi_rd, pi_wr); ai = $urandom; wi = rand_line();
         end
         if (!(pd_rd | pd_wr) && ($urandom_range(0, 1) == 1)) begin
            rand_op(pd_rd, pd_wr); ad = $urandom; wd = rand_line();
         end
         drive();
         if (pi_rd | pi_wr | pd_rd | pd_wr)
            run_txn($urandom_range(0, 15) == 0, $urandom_range(0, 3), rand_line());
         else begin
            @(posedge clk); #1;
            check_quiet("rand_idle");
         end
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
